// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel input debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b10,
    WAIT_LO   = 2'b11
  } state_e;

  // Counter only has to reach STABLE_CYCLES-1, so $clog2 of the count suffices.
  function automatic int cnt_width(input int stable_cycles);
    return (stable_cycles < 2) ? 1 : $clog2(stable_cycles);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser chain, stability counter, edge FSM.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic pulse_d
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dout_q, dout_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser stage: din is asynchronous, only s feeds the filter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Filter/output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign dout    = dout_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  // Exposed pre-register so the top can register any_edge in step with rise/fall.
  assign pulse_d = rise_d | fall_d;

endmodule

// File: rtl/debounce_edge.sv
// Multi-channel debouncer: WIDTH independent channels plus a shared any_edge flag.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_edge
);

  logic [WIDTH-1:0] pulse_d;
  logic             any_edge_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .din    (din[i]),
      .dout   (dout[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .pulse_d(pulse_d[i])
    );
  end

  // Registered from next-state pulses so it lands on the same cycle as rise/fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) any_edge_q <= 1'b0;
    else       any_edge_q <= |pulse_d;
  end

  assign any_edge = any_edge_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge at default parameters (18-edge latency).
module tb_debounce_edge;

  logic       clk;
  logic       reset;
  logic [3:0] din;
  logic [3:0] dout;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       any_edge;

  int n_chk;
  int n_pass;

  debounce_edge #(
    .WIDTH        (4),
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .din     (din),
    .dout    (dout),
    .rise    (rise),
    .fall    (fall),
    .any_edge(any_edge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks {dout, rise, fall, any_edge} as one 13-bit word.
  task automatic chk_all(input string tag, input logic [3:0] d, input logic [3:0] r,
                         input logic [3:0] f, input logic a);
    chk(tag, {19'd0, dout, rise, fall, any_edge}, {19'd0, d, r, f, a});
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    din    = 4'b0000;
    reset  = 1'b1;
    #1;
    chk_all("reset_async", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Reset held with quiet inputs.
    for (int i = 0; i < 40; i++) begin
      tick();
      chk_all("reset_hold", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("idle", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end

    // Single channel rise: accepted on the 18th edge.
    din[0] = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk_all("ch0_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    tick();
    chk_all("ch0_rise", 4'b0001, 4'b0001, 4'b0000, 1'b1);
    tick();
    chk_all("ch0_after", 4'b0001, 4'b0000, 4'b0000, 1'b0);

    // Short pulse on ch1 is rejected.
    din[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_all("ch1_short_hi", 4'b0001, 4'b0000, 4'b0000, 1'b0);
    end
    din[1] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      chk_all("ch1_short_lo", 4'b0001, 4'b0000, 4'b0000, 1'b0);
    end

    // ch2 bounces every 3 cycles for 30 cycles, then settles high.
    din[2] = 1'b1;
    for (int ph = 0; ph < 10; ph++) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        chk_all("ch2_bounce", 4'b0001, 4'b0000, 4'b0000, 1'b0);
      end
      din[2] = ~din[2];
    end
    din[2] = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk_all("ch2_settle", 4'b0001, 4'b0000, 4'b0000, 1'b0);
    end
    tick();
    chk_all("ch2_rise", 4'b0101, 4'b0100, 4'b0000, 1'b1);
    tick();
    chk_all("ch2_after", 4'b0101, 4'b0000, 4'b0000, 1'b0);

    // Bring ch3 high.
    din[3] = 1'b1;
    for (int k = 1; k <= 17; k++) tick();
    tick();
    chk_all("ch3_rise", 4'b1101, 4'b1000, 4'b0000, 1'b1);
    tick();

    // ch3 falls, reset hits mid-count: no fall pulse, partial count discarded.
    din[3] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_all("ch3_fall_wait", 4'b1101, 4'b0000, 4'b0000, 1'b0);
    end
    reset = 1'b1;
    #1;
    chk_all("midcount_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk_all("midcount_hold", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    reset = 1'b0;

    // ch0/ch2 still high through release: rise again after full latency.
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk_all("post_reset_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    tick();
    chk_all("post_reset_rise", 4'b0101, 4'b0101, 4'b0000, 1'b1);
    tick();
    chk_all("post_reset_after", 4'b0101, 4'b0000, 4'b0000, 1'b0);

    // All low: ch0 and ch2 fall together.
    din = 4'b0000;
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk_all("fall_wait", 4'b0101, 4'b0000, 4'b0000, 1'b0);
    end
    tick();
    chk_all("fall_pair", 4'b0000, 4'b0000, 4'b0101, 1'b1);
    tick();
    chk_all("fall_after", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Simultaneous rise on ch0 and ch1.
    din = 4'b0011;
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk_all("pair_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    tick();
    chk_all("pair_rise", 4'b0011, 4'b0011, 4'b0000, 1'b1);
    tick();
    chk_all("pair_after", 4'b0011, 4'b0000, 4'b0000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
